// File: rtl/pipe_mux.sv
// pipe_mux: N-way input select feeding a 2-entry skid FIFO.
//   clk, rst_n     : rising-edge clock, async active-low reset
//   in_data/sel    : NUM_IN packed inputs and their select, taken on accept
//   in_valid/in_ready   : upstream handshake (in_ready is purely registered)
//   out_data/out_err/out_valid/out_ready : head entry and downstream handshake
//   flush          : synchronous discard of every buffered entry
//   err_cnt        : saturating count of accepted illegal selects
module pipe_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic [7:0]              err_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } entry_t;

  state_t state, state_n;
  entry_t head, head_n, tail, tail_n, new_ent;

  // Per-lane select: one-hot hit, AND-OR reduction. An out-of-range sel
  // hits no lane, so data naturally collapses to zero and err is raised.
  logic [NUM_IN-1:0][WIDTH-1:0] lanes, masked;
  logic [NUM_IN-1:0]            hit;

  assign lanes = in_data;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
    assign hit[g]    = (sel == SEL_W'(g));
    assign masked[g] = hit[g] ? lanes[g] : '0;
  end

  always_comb begin
    new_ent.data = '0;
    for (int i = 0; i < NUM_IN; i++) new_ent.data = new_ent.data | masked[i];
    new_ent.err = ~|hit;
  end

  // Handshakes decode from registered state only.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = head.data;
  assign out_err   = head.err;

  logic accept, pop;
  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_n = state;
    head_n  = head;
    tail_n  = tail;
    case (state)
      EMPTY: if (accept) begin
        state_n = ONE;
        head_n  = new_ent;
      end
      ONE: begin
        if (accept && pop) head_n = new_ent;      // replace head in place
        else if (accept) begin
          state_n = FULL;
          tail_n  = new_ent;
        end else if (pop) state_n = EMPTY;
      end
      FULL: if (pop) begin                        // in_ready=0, no accept here
        state_n = ONE;
        head_n  = tail;
      end
      default: state_n = EMPTY;
    endcase
    if (flush) begin
      state_n = EMPTY;
      head_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_n;
      head  <= head_n;
      tail  <= tail_n;
    end
  end

  // Counts illegal accepts even when a same-cycle flush drops the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt <= '0;
    else if (accept && new_ent.err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end

endmodule
